// File: rtl/fetch_sequencer_if.sv
// +-----------------------------------------------------------------------------
// | fetch_sequencer_if : instruction-memory request/response bus
// | Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

interface fetch_sequencer_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;

  modport master (output req, output addr, input ready, input rdata);
  modport slave  (input req, input addr, output ready, output rdata);
endinterface

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// +-----------------------------------------------------------------------------
// | fetch_sequencer : IDLE/FETCH/ISSUE program-counter and fetch sequencer.
// | Optional macro FETCH_JUMP_EN enables the jump path.  Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        stall,
  input  wire logic        branch_taken,
  input  wire logic [31:0] branch_target,
  input  wire logic        jump,
  input  wire logic [25:0] jump_target,
  fetch_sequencer_if.master imem,
  output logic [31:0]      pc_out,
  output logic [31:0]      pc_plus4,
  output logic [31:0]      instr_out,
  output logic             instr_valid
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_inc;
  logic [31:0] next_pc;

  assign pc_inc = pc_q + 32'd4;

`ifdef FETCH_JUMP_EN
  logic unused_bits;
  assign unused_bits = ^branch_target[1:0];

  always_comb begin
    next_pc = pc_inc;
    if (jump) begin
      next_pc = {pc_inc[31:28], jump_target, 2'b00};
    end else if (branch_taken) begin
      next_pc = {branch_target[31:2], 2'b00};
    end
  end
`else
  // jump inputs stay on the port list so both builds share one pinout
  logic unused_bits;
  assign unused_bits = ^{jump, jump_target, branch_target[1:0]};

  always_comb begin
    next_pc = pc_inc;
    if (branch_taken) begin
      next_pc = {branch_target[31:2], 2'b00};
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem.ready) begin
          instr_d = imem.rdata;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!stall) begin
          pc_d    = next_pc;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    imem.req    = (state_q == ST_FETCH);
    imem.addr   = pc_q;
    instr_valid = (state_q == ST_ISSUE);
    pc_out      = pc_q;
    pc_plus4    = pc_inc;
    instr_out   = instr_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// +-----------------------------------------------------------------------------
// | tb_fetch_sequencer : directed + randomized bench with a behavioural model
// | Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module tb_fetch_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        jump = 1'b0;
  logic [25:0] jump_target = 26'h0;
  logic [31:0] pc_out, pc_plus4, instr_out;
  logic        instr_valid;

  fetch_sequencer_if imem_if ();

  fetch_sequencer #(.RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem          (imem_if.master),
    .pc_out        (pc_out),
    .pc_plus4      (pc_plus4),
    .instr_out     (instr_out),
    .instr_valid   (instr_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: "waiting for memory" and "holding an instruction"; neither means the idle gap.
  logic        m_fetching = 1'b0;
  logic        m_issuing  = 1'b0;
  logic [31:0] m_pc       = RESET_PC;
  logic [31:0] m_instr    = 32'h0;

  function automatic logic [31:0] ref_next_pc(input logic [31:0] pc);
    logic [31:0] seq;
    seq = pc + 32'd4;
`ifdef FETCH_JUMP_EN
    if (jump) return {seq[31:28], jump_target, 2'b00};
`endif
    if (branch_taken) return branch_target & 32'hFFFF_FFFC;
    return seq;
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      m_fetching = 1'b0;
      m_issuing  = 1'b0;
      m_pc       = RESET_PC;
      m_instr    = 32'h0;
    end else if (m_issuing) begin
      if (!stall) begin
        m_pc       = ref_next_pc(m_pc);
        m_issuing  = 1'b0;
        m_fetching = 1'b1;
      end
    end else if (m_fetching) begin
      if (imem_if.ready) begin
        m_instr    = imem_if.rdata;
        m_fetching = 1'b0;
        m_issuing  = 1'b1;
      end
    end else begin
      m_fetching = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all();
    chk("imem_req", {31'b0, imem_if.req}, {31'b0, m_fetching});
    if (m_fetching) chk("imem_addr", imem_if.addr, m_pc);
    chk("pc_out", pc_out, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("instr_out", instr_out, m_instr);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_issuing});
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic quiet_inputs();
    stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_target = 32'h0; jump_target = 26'h0;
  endtask

  // Advance with memory always ready until an instruction is held (bounded).
  task automatic go_issue(input string tag);
    int n;
    n = 0;
    quiet_inputs();
    imem_if.ready = 1'b1;
    while (!m_issuing && n < 8) begin
      imem_if.rdata = $urandom;
      cycle();
      n++;
    end
    chk({tag, "_reach_issue"}, {31'b0, instr_valid}, 32'd1);
  endtask

  // From ISSUE, redirect to a given PC via a taken branch and hold there in ISSUE.
  task automatic goto_pc(input logic [31:0] pc);
    go_issue("goto");
    branch_taken = 1'b1; branch_target = pc;
    imem_if.ready = 1'b0;
    cycle();
    go_issue("goto_pc");
    chk("goto_pc_value", pc_out, pc);
  endtask

  initial begin
    logic [31:0] seen [3];
    logic [31:0] hold_pc, hold_instr, late_data;
    int k;

    seen = '{default: 32'hFFFF_FFFF};
    imem_if.ready = 1'b0;
    imem_if.rdata = 32'h0;

    // Reset state
    rst_n = 1'b0;
    cycle();
    cycle();
    chk("rst_pc", pc_out, RESET_PC);
    chk("rst_instr", instr_out, 32'h0);
    chk("rst_req", {31'b0, imem_if.req}, 32'd0);

    // Back-to-back fetch with memory always ready: 0,4,8 and a 2-cycle cadence
    rst_n = 1'b1;
    imem_if.ready = 1'b1;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      imem_if.rdata = $urandom;
      cycle();
      if (imem_if.req && k < 3) begin
        seen[k] = imem_if.addr;
        k++;
      end
      chk("cadence_valid", {31'b0, instr_valid}, (c % 2 == 1) ? 32'd1 : 32'd0);
    end
    chk("seq_addr0", seen[0], 32'h0);
    chk("seq_addr1", seen[1], 32'h4);
    chk("seq_addr2", seen[2], 32'h8);

    // Branch target low bits discarded
    goto_pc(32'h0000_0100);
    branch_taken = 1'b1; branch_target = 32'h0000_0203;
    cycle();
    chk("branch_addr", imem_if.addr, 32'h0000_0200);

    // Jump vs branch priority
    goto_pc(32'h1000_0000);
    jump = 1'b1; jump_target = 26'h0000040;
    branch_taken = 1'b1; branch_target = 32'h0000_2000;
    cycle();
`ifdef FETCH_JUMP_EN
    chk("jump_prio_addr", imem_if.addr, 32'h1000_0100);
`else
    chk("jump_ignored_addr", imem_if.addr, 32'h0000_2000);
`endif

    // Stall holds everything, redirect requests ignored
    go_issue("stall");
    hold_pc = pc_out;
    hold_instr = instr_out;
    stall = 1'b1;
    for (int c = 0; c < 5; c++) begin
      branch_taken = 1'($urandom); jump = 1'($urandom);
      branch_target = $urandom; jump_target = 26'($urandom);
      imem_if.ready = 1'($urandom);
      cycle();
      chk("stall_pc", pc_out, hold_pc);
      chk("stall_instr", instr_out, hold_instr);
      chk("stall_valid", {31'b0, instr_valid}, 32'd1);
      chk("stall_req", {31'b0, imem_if.req}, 32'd0);
    end

    // Slow memory, then reset during the wait with a late ready
    quiet_inputs();
    imem_if.ready = 1'b0;
    cycle();
    hold_pc = imem_if.addr;
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("wait_req", {31'b0, imem_if.req}, 32'd1);
      chk("wait_addr", imem_if.addr, hold_pc);
    end
    late_data = 32'hDEAD_BEEF;
    rst_n = 1'b0;
    imem_if.ready = 1'b1;
    imem_if.rdata = late_data;
    cycle();
    chk("rst_wait_pc", pc_out, RESET_PC);
    chk("rst_wait_instr", instr_out, 32'h0);
    rst_n = 1'b1;
    cycle();  // IDLE: ready must be ignored
    chk("idle_ready_ignored", instr_out, 32'h0);

    // PC wrap
    goto_pc(32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus4, 32'h0);
    quiet_inputs();
    cycle();
    chk("wrap_addr", imem_if.addr, 32'h0);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      rst_n = ($urandom_range(0, 39) != 0);
      stall = ($urandom_range(0, 2) == 0);
      branch_taken = 1'($urandom);
      branch_target = $urandom;
      jump = ($urandom_range(0, 3) == 0);
      jump_target = 26'($urandom);
      imem_if.ready = 1'($urandom);
      imem_if.rdata = $urandom;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
